// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM encoding and index-width helper for the FIFO push arbiter.
`default_nettype none

package fifo_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting just above the last winner, with wrap.
`default_nettype none

module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    always_comb begin
        int   idx;
        logic found;
        winner    = '0;
        found     = 1'b0;
        idx       = 0;
        any_valid = |req;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter granting bursts of up to MAX_BURST words into one FIFO.
`default_nettype none

module fifo_push_arbiter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_push,
    output logic [WIDTH-1:0]        fifo_wdata,
    output logic [idw(NREQ)-1:0]    grant_id,
    output logic                    busy
);

    localparam int IDW = idw(NREQ);
    localparam int CW  = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

    logic [0:0]     state;
    logic [IDW-1:0] last_grant;
    logic [CW-1:0]  count;

    logic [IDW-1:0] pick;
    logic           any_valid;
    logic           owner_valid;
    logic           xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req       (req_valid),
        .last      (last_grant),
        .winner    (pick),
        .any_valid (any_valid)
    );

    // The owner is always last_grant: it is registered together with the grant.
    assign owner_valid = req_valid[last_grant];
    assign xfer        = (state == ST_BURST) && owner_valid && !fifo_full;

    assign fifo_push  = xfer;
    assign req_ready  = xfer ? (NREQ'(1) << last_grant) : '0;
    assign fifo_wdata = (state == ST_BURST) ? req_data[last_grant*WIDTH +: WIDTH] : '0;
    assign grant_id   = last_grant;
    assign busy       = (state == ST_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        last_grant <= pick;
                        count      <= '0;
                        state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!owner_valid) begin
                        state <= ST_IDLE;
                    end else if (!fifo_full) begin
                        count <= count + CW'(1);
                        if (count == CW'(MAX_BURST - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized and directed checks against a behavioural arbitration model.
`default_nettype none

module tb_fifo_push_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_push;
    logic [WIDTH-1:0]  fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Requester sources and FIFO-side scoreboard
    int src_seq[NREQ];
    int sb_cnt[NREQ];
    int push_total;
    logic [7:0] pushed[$];

    // Behavioural model: "in a burst", its owner, words taken so far, last winner
    bit m_burst;
    int m_owner;
    int m_cnt;
    int m_last;

    fifo_push_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] word_of(input int i, input int s);
        return 8'(i * 64 + 16 + s);
    endfunction

    task automatic model_reset();
        m_burst = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = NREQ - 1;
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model at posedge.
    task automatic cycle(input logic [3:0] v, input logic full);
        logic       exp_push;
        logic [3:0] exp_ready;
        logic [7:0] exp_wdata;
        bit         found;
        @(negedge clk);
        req_valid = v;
        fifo_full = full;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = word_of(i, src_seq[i]);
        #1;
        exp_push  = m_burst && v[m_owner] && !full;
        exp_ready = exp_push ? 4'(1 << m_owner) : 4'b0;
        exp_wdata = m_burst ? word_of(m_owner, src_seq[m_owner]) : 8'h00;

        checks++;
        if (fifo_push !== exp_push) begin
            failures++;
            $display("FAIL push t=%0t got=%b exp=%b", $time, fifo_push, exp_push);
        end
        checks++;
        if (req_ready !== exp_ready) begin
            failures++;
            $display("FAIL ready t=%0t got=%b exp=%b", $time, req_ready, exp_ready);
        end
        checks++;
        if (fifo_wdata !== exp_wdata) begin
            failures++;
            $display("FAIL wdata t=%0t got=%h exp=%h", $time, fifo_wdata, exp_wdata);
        end
        checks++;
        if (busy !== m_burst) begin
            failures++;
            $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_burst);
        end
        checks++;
        if (grant_id !== 2'(m_last)) begin
            failures++;
            $display("FAIL grant_id t=%0t got=%0d exp=%0d", $time, grant_id, m_last);
        end
        checks++;
        if ((req_ready & ~(4'b1 << grant_id)) !== 4'b0 || (fifo_push === 1'b1 && full)) begin
            failures++;
            $display("FAIL invariant t=%0t ready=%b gid=%0d push=%b full=%b",
                     $time, req_ready, grant_id, fifo_push, full);
        end
        if (fifo_push === 1'b1) begin
            checks++;
            if (fifo_wdata !== word_of(m_owner, sb_cnt[m_owner])) begin
                failures++;
                $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, fifo_wdata,
                         word_of(m_owner, sb_cnt[m_owner]));
            end
            sb_cnt[m_owner]++;
            push_total++;
            pushed.push_back(fifo_wdata);
        end

        for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) src_seq[i]++;

        if (m_burst) begin
            if (!v[m_owner]) begin
                m_burst = 1'b0;
            end else if (!full) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) m_burst = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && v[(m_last + k) % NREQ]) begin
                    found   = 1'b1;
                    m_owner = (m_last + k) % NREQ;
                end
            end
            if (found) begin
                m_last  = m_owner;
                m_cnt   = 0;
                m_burst = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    // Asserts rst asynchronously (inputs left as they are), checks outputs, releases with inputs idle.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_push !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 ||
            fifo_wdata !== 8'h00 || grant_id !== 2'd3) begin
            failures++;
            $display("FAIL %s outputs push=%b ready=%b busy=%b wdata=%h gid=%0d",
                     tag, fifo_push, req_ready, busy, fifo_wdata, grant_id);
        end
        model_reset();
        @(negedge clk);
        req_valid = '0;
        fifo_full = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_seq[i] = 0;
            sb_cnt[i]  = 0;
        end
        push_total = 0;
        req_valid  = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        rst        = 1'b0;
        pulse_reset("reset");
    endtask

    task automatic test_single_requester();
        pushed.delete();
        for (int c = 0; c < 10; c++) cycle(4'b0001, 1'b0);
        checks++;
        if (pushed.size() != 8) begin
            failures++;
            $display("FAIL single_count got=%0d exp=8", pushed.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pushed[i] !== 8'(8'h10 + i)) begin
                    failures++;
                    $display("FAIL single_word[%0d] got=%h exp=%h", i, pushed[i], 8'(8'h10 + i));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int   order[$];
        logic prev;
        int   base;
        pulse_reset("rr_reset");
        base = push_total;
        prev = 1'b0;
        for (int c = 0; c < 25; c++) begin
            cycle(4'b1111, 1'b0);
            #1;
            if (busy === 1'b1 && !prev) order.push_back(int'(grant_id));
            prev = busy;
        end
        checks++;
        if (push_total - base != 20 || order.size() != 5) begin
            failures++;
            $display("FAIL rr_counts pushes=%0d bursts=%0d exp=20/5", push_total - base, order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != i % NREQ) begin
                    failures++;
                    $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], i % NREQ);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int base;
        pulse_reset("stall_reset");
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        base = push_total;
        for (int c = 0; c < 5; c++) cycle(4'b0100, 1'b1);
        checks++;
        if (push_total != base || grant_id !== 2'd2) begin
            failures++;
            $display("FAIL stall pushes=%0d gid=%0d exp=0/2", push_total - base, grant_id);
        end
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        checks++;
        if (push_total - base != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume pushes=%0d busy=%b exp=2/0", push_total - base, busy);
        end
    endtask

    task automatic test_drop_valid();
        pulse_reset("drop_reset");
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle busy=%b exp=0", busy);
        end
        cycle(4'b1111, 1'b0);
        #1;
        checks++;
        if (grant_id !== 2'd2) begin
            failures++;
            $display("FAIL drop_next gid=%0d exp=2", grant_id);
        end
        for (int c = 0; c < 5; c++) cycle(4'b1111, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        pulse_reset("mid_pre_reset");
        for (int c = 0; c < 4; c++) cycle(4'b1111, 1'b0);
        req_valid = 4'b1111;
        pulse_reset("mid_reset");
        cycle(4'b0110, 1'b0);
        #1;
        checks++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_regrant gid=%0d busy=%b exp=1/1", grant_id, busy);
        end
        for (int c = 0; c < 6; c++) cycle(4'b0110, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       f;
        pulse_reset("rand_reset");
        v = 4'($urandom_range(0, 15));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 3) == 0);
            cycle(v, f);
            if ($urandom_range(0, 199) == 0) pulse_reset("rand_midreset");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_requester();
        test_round_robin();
        test_full_stall();
        test_drop_valid();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
